cmp_stream_tracker: RTL and testbench
=====================================

Name: cmp_stream_tracker

Overview:
- Parametrised, registered successor to the team's combinational magnitude comparator.
- Per beat, compares sample `a` against threshold `b`, with runtime signed/unsigned mode.
- Over a framed stream of `a` samples it also tracks:
  - minimum and maximum, with first-occurrence indices;
  - beat count;
  - count of beats above threshold.
- Sits between datapath producers and control logic that needs per-frame statistics instead of single comparisons.

Parameters:
- DATAWIDTH, 32, width of `a` and `b`.
- CNTWIDTH, 8, width of index and count fields; all counters saturate at 2^CNTWIDTH-1.

Ports:
- Clk  input  1  clock; all logic on rising edge.
- Rst  input  1  synchronous, active-high reset.
- in_valid  input  1  beat qualifier.
- in_first  input  1  first beat of frame; only meaningful with in_valid.
- in_last  input  1  last beat of frame; only meaningful with in_valid.
- sgn  input  1  1 = two's-complement compare, 0 = unsigned.
- a  input  DATAWIDTH  sample.
- b  input  DATAWIDTH  threshold.
- out_valid  output  1  per-beat result valid.
- gt  output  1  a > b for that beat.
- lt  output  1  a < b for that beat.
- eq  output  1  a == b for that beat.
- busy  output  1  frame open.
- done  output  1  one-cycle pulse: frame results updated.
- min_val  output  DATAWIDTH  frame minimum of `a`.
- max_val  output  DATAWIDTH  frame maximum of `a`.
- min_idx  output  CNTWIDTH  index of first occurrence of the minimum.
- max_idx  output  CNTWIDTH  index of first occurrence of the maximum.
- count  output  CNTWIDTH  beats in frame.
- above_cnt  output  CNTWIDTH  beats with a > b.
- ovf  output  1  frame exceeded 2^CNTWIDTH-1 beats.

Behaviour:
- Clock and reset: single clock Clk; reset Rst is synchronous and active-high.
- Reset values: all outputs 0.
  - Covers out_valid, gt/lt/eq, busy, done, min/max values, indices, count, above_cnt and ovf.
  - FSM state on reset: IDLE.
- Per-beat compare:
  - Latency 1: out_valid = in_valid delayed one cycle.
  - gt/lt/eq are registered and one-hot whenever out_valid = 1.
  - gt/lt/eq hold their last value when out_valid = 0.
  - Compare mode is the current beat's `sgn`.
  - The per-beat compare operates independently of frame state.
- FSM states: IDLE and ACTIVE.
- IDLE -> ACTIVE on in_valid & in_first & ~in_last.
  - Latches the tracker mode from `sgn`; that mode holds for the whole frame.
  - Loads the working registers: min = max = a, min_idx = max_idx = 0, cnt = 1, above = (a > b).
- ACTIVE beat with in_valid & ~in_first:
  - Strict compare updates the working minimum and maximum; ties keep the earlier index.
  - Index = current cnt.
  - cnt and above increment, saturating.
  - On saturation, the ovf working flag is set.
- ACTIVE with in_last (the last beat is included in the statistics):
  - Working registers are copied to the visible outputs.
  - done = 1 on the next cycle.
  - FSM -> IDLE.
- in_first & in_last on the same beat, from any state:
  - Single-beat frame: min = max = a, indices 0, count = 1.
  - done pulses; FSM ends in IDLE.
- in_first while ACTIVE:
  - The current frame is abandoned without a done pulse.
  - The new frame starts from the current beat.
- in_valid without in_first while IDLE: ignored by the tracker.
- Visible frame outputs change only on a done cycle and hold between frames.
- busy = 1 exactly while in ACTIVE.
- Rst mid-frame: frame discarded, no done, all outputs return to reset values on the next edge.
- in_valid = 0 during ACTIVE: stall; no state change.

Test Plan:
- DATAWIDTH=8, CNTWIDTH=4, Rst for 2 cycles, then in_valid=1, a=5, b=5, sgn=0 -> next cycle out_valid=1, eq=1, gt=lt=0; all frame outputs 0.
- a=8'hFF, b=8'h01: with sgn=1 -> lt=1; next beat with sgn=0 -> gt=1. Results appear back-to-back on consecutive cycles.
- Frame a=3,9,1,9,1 with b=4, sgn=0, in_first on beat 0, in_last on beat 4 -> done one cycle after beat 4, max_val=9, max_idx=1, min_val=1, min_idx=2, count=5, above_cnt=2, busy then 0.
- Frame with sgn=1, a=8'h80, 8'h7F, b=0:
  - Expected: min_val=8'h80, max_val=8'h7F, above_cnt=1.
  - Then a single beat with in_first&in_last, a=7 -> min=max=7, count=1, done pulse.
- 17-beat frame with a=1 throughout -> count=15, ovf=1, min_idx=max_idx=0.
- Abandon/reset cases, checked separately:
  - in_first on beat 2 of an open frame -> no done for the first frame; the second frame's statistics exclude earlier beats.
  - Rst mid-frame -> busy=0, all outputs 0, no done.

Source files
------------

// File: rtl/cmp_stream_tracker.sv
// Registered per-beat magnitude compare (signed/unsigned at runtime) plus
// per-frame min/max/count/above-threshold statistics over a framed stream.
module cmp_stream_tracker #(
  parameter int DATAWIDTH = 32,
  parameter int CNTWIDTH  = 8
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 in_valid,
  input  logic                 in_first,
  input  logic                 in_last,
  input  logic                 sgn,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic                 out_valid,
  output logic                 gt,
  output logic                 lt,
  output logic                 eq,
  output logic                 busy,
  output logic                 done,
  output logic [DATAWIDTH-1:0] min_val,
  output logic [DATAWIDTH-1:0] max_val,
  output logic [CNTWIDTH-1:0]  min_idx,
  output logic [CNTWIDTH-1:0]  max_idx,
  output logic [CNTWIDTH-1:0]  count,
  output logic [CNTWIDTH-1:0]  above_cnt,
  output logic                 ovf
);

  localparam logic [CNTWIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNTWIDTH-1:0] CNT_ONE = CNTWIDTH'(1);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t               state_q;

  logic                 wsgn_q;
  logic [DATAWIDTH-1:0] wmin_q, wmax_q;
  logic [CNTWIDTH-1:0]  wmin_idx_q, wmax_idx_q, wcnt_q, wabove_q;
  logic                 wovf_q;

  logic [DATAWIDTH-1:0] wmin_d, wmax_d;
  logic [CNTWIDTH-1:0]  wmin_idx_d, wmax_idx_d, wcnt_d, wabove_d;
  logic                 wovf_d;

  logic                 single_beat, start_frame, extend_frame, close_frame;

  function automatic logic is_gt(input logic [DATAWIDTH-1:0] x,
                                 input logic [DATAWIDTH-1:0] y,
                                 input logic                 s);
    if (s) return $signed(x) > $signed(y);
    return x > y;
  endfunction

  function automatic logic [CNTWIDTH-1:0] sat_inc(input logic [CNTWIDTH-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  assign single_beat  = in_valid & in_first & in_last;
  assign start_frame  = in_valid & in_first & ~in_last;
  assign extend_frame = in_valid & ~in_first & (state_q == ACTIVE);
  assign close_frame  = extend_frame & in_last;
  assign busy         = (state_q == ACTIVE);

  // Working statistics if the current beat extends the open frame; strict
  // compares keep the earliest index on ties.
  always_comb begin
    wmin_d     = wmin_q;
    wmax_d     = wmax_q;
    wmin_idx_d = wmin_idx_q;
    wmax_idx_d = wmax_idx_q;
    if (is_gt(wmin_q, a, wsgn_q)) begin
      wmin_d     = a;
      wmin_idx_d = wcnt_q;
    end
    if (is_gt(a, wmax_q, wsgn_q)) begin
      wmax_d     = a;
      wmax_idx_d = wcnt_q;
    end
    wcnt_d   = sat_inc(wcnt_q);
    wabove_d = is_gt(a, b, wsgn_q) ? sat_inc(wabove_q) : wabove_q;
    wovf_d   = wovf_q | (wcnt_q == CNT_MAX);
  end

  // Working registers are always loaded before use, so they carry no reset.
  always_ff @(posedge Clk) begin
    if (in_valid && in_first) begin
      wsgn_q     <= sgn;
      wmin_q     <= a;
      wmax_q     <= a;
      wmin_idx_q <= '0;
      wmax_idx_q <= '0;
      wcnt_q     <= CNT_ONE;
      wabove_q   <= is_gt(a, b, sgn) ? CNT_ONE : '0;
      wovf_q     <= 1'b0;
    end else if (extend_frame) begin
      wmin_q     <= wmin_d;
      wmax_q     <= wmax_d;
      wmin_idx_q <= wmin_idx_d;
      wmax_idx_q <= wmax_idx_d;
      wcnt_q     <= wcnt_d;
      wabove_q   <= wabove_d;
      wovf_q     <= wovf_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q   <= IDLE;
      out_valid <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      eq        <= 1'b0;
      done      <= 1'b0;
      min_val   <= '0;
      max_val   <= '0;
      min_idx   <= '0;
      max_idx   <= '0;
      count     <= '0;
      above_cnt <= '0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      done      <= 1'b0;
      if (in_valid) begin
        gt <= is_gt(a, b, sgn);
        lt <= is_gt(b, a, sgn);
        eq <= (a == b);
      end
      if (single_beat) begin
        state_q   <= IDLE;
        min_val   <= a;
        max_val   <= a;
        min_idx   <= '0;
        max_idx   <= '0;
        count     <= CNT_ONE;
        above_cnt <= is_gt(a, b, sgn) ? CNT_ONE : '0;
        ovf       <= 1'b0;
        done      <= 1'b1;
      end else if (start_frame) begin
        state_q <= ACTIVE;
      end else if (close_frame) begin
        state_q   <= IDLE;
        min_val   <= wmin_d;
        max_val   <= wmax_d;
        min_idx   <= wmin_idx_d;
        max_idx   <= wmax_idx_d;
        count     <= wcnt_d;
        above_cnt <= wabove_d;
        ovf       <= wovf_d;
        done      <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmp_stream_tracker.sv
// Scoreboard bench for cmp_stream_tracker: a frame-level reference model
// queues expected beat and frame results; a monitor pops them on out_valid/done.
module tb_cmp_stream_tracker;

  localparam int DW   = 8;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, sgn = 1'b0;
  logic [DW-1:0] a = '0, b = '0;
  logic          out_valid, gt, lt, eq, busy, done, ovf;
  logic [DW-1:0] min_val, max_val;
  logic [CW-1:0] min_idx, max_idx, count, above_cnt;

  cmp_stream_tracker #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
    .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .sgn(sgn), .a(a), .b(b), .out_valid(out_valid),
    .gt(gt), .lt(lt), .eq(eq), .busy(busy), .done(done),
    .min_val(min_val), .max_val(max_val), .min_idx(min_idx),
    .max_idx(max_idx), .count(count), .above_cnt(above_cnt), .ovf(ovf)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [DW-1:0] mn;
    logic [DW-1:0] mx;
    logic [CW-1:0] mni;
    logic [CW-1:0] mxi;
    logic [CW-1:0] cnt;
    logic [CW-1:0] abv;
    logic          ovf;
  } frame_t;

  logic [2:0]    beat_q[$];
  frame_t        frame_q[$];
  logic [2:0]    last_cmp = '0;
  frame_t        last_frame = '0;
  logic [2:0]    e_beat;
  frame_t        e_frame;

  bit            open = 1'b0;
  bit            mode = 1'b0;
  logic [DW-1:0] fa[$];
  logic [DW-1:0] fb[$];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int val(input logic [DW-1:0] x, input bit s);
    if (s) return int'($signed(x));
    return int'(x);
  endfunction

  function automatic int sat(input int x);
    return (x > CMAX) ? CMAX : x;
  endfunction

  function automatic frame_t dut_frame();
    return frame_t'({min_val, max_val, min_idx, max_idx, count, above_cnt, ovf});
  endfunction

  // Statistics of the whole recorded frame, computed directly from the beats.
  function automatic frame_t calc_frame();
    frame_t f;
    int n   = fa.size();
    int mni = 0;
    int mxi = 0;
    int ab  = 0;
    for (int i = 1; i < n; i++) begin
      if (val(fa[i], mode) < val(fa[mni], mode)) mni = i;
      if (val(fa[i], mode) > val(fa[mxi], mode)) mxi = i;
    end
    for (int i = 0; i < n; i++)
      if (val(fa[i], mode) > val(fb[i], mode)) ab++;
    f.mn  = fa[mni];
    f.mx  = fa[mxi];
    f.mni = CW'(sat(mni));
    f.mxi = CW'(sat(mxi));
    f.cnt = CW'(sat(n));
    f.abv = CW'(sat(ab));
    f.ovf = (n > CMAX);
    return f;
  endfunction

  task automatic model_beat(input bit f, input bit l, input bit s,
                            input logic [DW-1:0] av, input logic [DW-1:0] bv);
    beat_q.push_back({val(av, s) > val(bv, s), val(av, s) < val(bv, s), av == bv});
    if (f) begin
      fa.delete();
      fb.delete();
      mode = s;
      fa.push_back(av);
      fb.push_back(bv);
      if (l) begin
        frame_q.push_back(calc_frame());
        open = 1'b0;
      end else begin
        open = 1'b1;
      end
    end else if (open) begin
      fa.push_back(av);
      fb.push_back(bv);
      if (l) begin
        frame_q.push_back(calc_frame());
        open = 1'b0;
      end
    end
  endtask

  task automatic drive(input bit v, input bit f, input bit l, input bit s,
                       input logic [DW-1:0] av, input logic [DW-1:0] bv);
    @(negedge Clk);
    in_valid = v; in_first = f; in_last = l; sgn = s; a = av; b = bv;
    if (v) model_beat(f, l, s, av, bv);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic do_reset(input int n);
    @(negedge Clk);
    Rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    open = 1'b0;
    fa.delete();
    fb.delete();
    last_cmp   = '0;
    last_frame = '0;
    repeat (n) @(negedge Clk);
    Rst = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd8();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h7F;
      2: return 8'h80;
      3: return 8'hFF;
      4: return 8'(($urandom_range(0, 3)));
      default: return 8'($urandom);
    endcase
  endfunction

  // Monitor: one step after each rising edge, pop on out_valid/done, else check hold.
  always @(posedge Clk) begin
    #1;
    chk("busy", busy, open);
    if (out_valid) begin
      if (beat_q.size() == 0) chk("unexpected_out_valid", 1, 0);
      else begin
        e_beat = beat_q.pop_front();
        chk("beat_gt_lt_eq", {gt, lt, eq}, e_beat);
        last_cmp = e_beat;
      end
    end else begin
      chk("cmp_hold", {gt, lt, eq}, last_cmp);
    end
    if (done) begin
      if (frame_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e_frame = frame_q.pop_front();
        chk("frame_stats", dut_frame(), e_frame);
        last_frame = e_frame;
      end
    end else begin
      chk("frame_hold", dut_frame(), last_frame);
    end
  end

  initial begin
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    chk("reset_outputs", {out_valid, gt, lt, eq, busy, done, dut_frame()}, 0);

    // Equal compare, then signed/unsigned back-to-back
    drive(1, 0, 0, 0, 8'd5, 8'd5);
    idle(1);
    chk("eq_valid", {out_valid, gt, lt, eq}, 4'b1001);
    chk("eq_frame_zero", dut_frame(), 0);
    drive(1, 0, 0, 1, 8'hFF, 8'h01);
    drive(1, 0, 0, 0, 8'hFF, 8'h01);
    chk("signed_lt", {out_valid, gt, lt, eq}, 4'b1010);
    idle(1);
    chk("unsigned_gt", {out_valid, gt, lt, eq}, 4'b1100);
    idle(1);

    // Frame 3,9,1,9,1 against 4
    drive(1, 1, 0, 0, 8'd3, 8'd4);
    drive(1, 0, 0, 0, 8'd9, 8'd4);
    drive(1, 0, 0, 0, 8'd1, 8'd4);
    drive(1, 0, 0, 0, 8'd9, 8'd4);
    drive(1, 0, 1, 0, 8'd1, 8'd4);
    idle(1);
    chk("frame1_done_busy", {done, busy}, 2'b10);
    chk("frame1_stats", dut_frame(), frame_t'{8'd1, 8'd9, 4'd2, 4'd1, 4'd5, 4'd2, 1'b0});
    idle(1);
    chk("done_one_cycle", done, 0);

    // Signed frame, then single-beat frame
    drive(1, 1, 0, 1, 8'h80, 8'h00);
    drive(1, 0, 1, 0, 8'h7F, 8'h00);
    idle(1);
    chk("signed_frame", dut_frame(), frame_t'{8'h80, 8'h7F, 4'd0, 4'd1, 4'd2, 4'd1, 1'b0});
    drive(1, 1, 1, 0, 8'd7, 8'd0);
    idle(1);
    chk("single_beat", {done, dut_frame()}, {1'b1, frame_t'{8'd7, 8'd7, 4'd0, 4'd0, 4'd1, 4'd1, 1'b0}});

    // 15 beats: saturated count without overflow; 17 beats with stalls: overflow
    for (int i = 0; i < 15; i++) drive(1, i == 0, i == 14, 0, 8'd1, 8'd0);
    idle(1);
    chk("cnt15_no_ovf", dut_frame(), frame_t'{8'd1, 8'd1, 4'd0, 4'd0, 4'd15, 4'd15, 1'b0});
    for (int i = 0; i < 17; i++) begin
      drive(1, i == 0, i == 16, 0, 8'd1, 8'd0);
      if (i % 5 == 2) idle(2);
    end
    idle(1);
    chk("cnt17_ovf", dut_frame(), frame_t'{8'd1, 8'd1, 4'd0, 4'd0, 4'd15, 4'd15, 1'b1});

    // Abandoned frame: restart on beat 2
    drive(1, 1, 0, 0, 8'd5, 8'd0);
    drive(1, 0, 0, 0, 8'd200, 8'd0);
    drive(1, 1, 0, 0, 8'd20, 8'd0);
    idle(1);
    chk("abandon_no_done", {done, busy}, 2'b01);
    drive(1, 0, 1, 0, 8'd30, 8'd0);
    idle(1);
    chk("abandon_stats", dut_frame(), frame_t'{8'd20, 8'd30, 4'd0, 4'd1, 4'd2, 4'd2, 1'b0});

    // Reset mid-frame
    drive(1, 1, 0, 0, 8'd9, 8'd1);
    drive(1, 0, 0, 0, 8'd4, 8'd1);
    do_reset(1);
    chk("midframe_reset", {out_valid, gt, lt, eq, busy, done, dut_frame()}, 0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 149) == 0) do_reset($urandom_range(1, 2));
      else drive($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 11) == 0, 1'($urandom_range(0, 1)), rnd8(), rnd8());
    end
    idle(3);
    chk("beat_queue_drained", beat_q.size(), 0);
    chk("frame_queue_drained", frame_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
